// File: rtl/axi4_burst_master.sv
// Single-outstanding AXI4 burst master: accepts one read or write command at a time,
// streams write beats from wr_* and forwards read beats to rd_*, then pulses done.
module axi4_burst_master #(
    parameter int unsigned DATA_WIDTH = 512,
    parameter int unsigned ADDR_WIDTH = 6,
    parameter int unsigned ID_WIDTH   = 1
) (
    input  logic                    m00_axi_aclk,
    input  logic                    m00_axi_areset,
    // command
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_write,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [7:0]              cmd_len,
    // write source
    input  logic [DATA_WIDTH-1:0]   wr_data,
    input  logic                    wr_valid,
    output logic                    wr_ready,
    // read sink
    output logic [DATA_WIDTH-1:0]   rd_data,
    output logic                    rd_valid,
    input  logic                    rd_ready,
    // status
    output logic                    done,
    output logic [1:0]              done_resp,
    // AW
    output logic [ID_WIDTH-1:0]     m00_axi_awid,
    output logic [ADDR_WIDTH-1:0]   m00_axi_awaddr,
    output logic [7:0]              m00_axi_awlen,
    output logic [2:0]              m00_axi_awsize,
    output logic [1:0]              m00_axi_awburst,
    output logic                    m00_axi_awvalid,
    input  logic                    m00_axi_awready,
    // W
    output logic [DATA_WIDTH-1:0]   m00_axi_wdata,
    output logic [DATA_WIDTH/8-1:0] m00_axi_wstrb,
    output logic                    m00_axi_wlast,
    output logic                    m00_axi_wvalid,
    input  logic                    m00_axi_wready,
    // B
    input  logic [ID_WIDTH-1:0]     m00_axi_bid,
    input  logic [1:0]              m00_axi_bresp,
    input  logic                    m00_axi_bvalid,
    output logic                    m00_axi_bready,
    // AR
    output logic [ID_WIDTH-1:0]     m00_axi_arid,
    output logic [ADDR_WIDTH-1:0]   m00_axi_araddr,
    output logic [7:0]              m00_axi_arlen,
    output logic [2:0]              m00_axi_arsize,
    output logic [1:0]              m00_axi_arburst,
    output logic                    m00_axi_arvalid,
    input  logic                    m00_axi_arready,
    // R
    input  logic [ID_WIDTH-1:0]     m00_axi_rid,
    input  logic [DATA_WIDTH-1:0]   m00_axi_rdata,
    input  logic [1:0]              m00_axi_rresp,
    input  logic                    m00_axi_rlast,
    input  logic                    m00_axi_rvalid,
    output logic                    m00_axi_rready
);

    localparam int unsigned StrbWidth = DATA_WIDTH / 8;
    localparam logic [2:0]  AxSize    = 3'($clog2(StrbWidth));

    typedef enum logic [2:0] {
        StIdle,
        StWaddr,
        StWdata,
        StWresp,
        StRaddr,
        StRdata
    } state_e;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [7:0]              len_q, len_d;
    logic [7:0]              count_q, count_d;
    logic [1:0]              resp_max_q, resp_max_d;
    logic                    len_err_q, len_err_d;   // beat count reached len without rlast
    logic                    done_q, done_d;
    logic [1:0]              done_resp_q, done_resp_d;
    logic [1:0]              resp_max_now;

    // IDs only matter for multi-outstanding masters; this one issues a single transaction
    logic unused_ids;
    assign unused_ids = ^{m00_axi_bid, m00_axi_rid};

    assign m00_axi_awid    = '0;
    assign m00_axi_arid    = '0;
    assign m00_axi_awsize  = AxSize;
    assign m00_axi_arsize  = AxSize;
    assign m00_axi_awburst = 2'b01;
    assign m00_axi_arburst = 2'b01;
    assign m00_axi_awaddr  = addr_q;
    assign m00_axi_araddr  = addr_q;
    assign m00_axi_awlen   = len_q;
    assign m00_axi_arlen   = len_q;
    assign m00_axi_wdata   = wr_data;
    assign m00_axi_wstrb   = '1;
    assign rd_data         = m00_axi_rdata;
    assign done            = done_q;
    assign done_resp       = done_resp_q;

    assign resp_max_now = (m00_axi_rresp > resp_max_q) ? m00_axi_rresp : resp_max_q;

    // Next-state, handshake outputs and completion bookkeeping
    always_comb begin
        state_d         = state_q;
        addr_d          = addr_q;
        len_d           = len_q;
        count_d         = count_q;
        resp_max_d      = resp_max_q;
        len_err_d       = len_err_q;
        done_d          = 1'b0;
        done_resp_d     = done_resp_q;
        cmd_ready       = 1'b0;
        wr_ready        = 1'b0;
        rd_valid        = 1'b0;
        m00_axi_awvalid = 1'b0;
        m00_axi_wvalid  = 1'b0;
        m00_axi_wlast   = 1'b0;
        m00_axi_bready  = 1'b0;
        m00_axi_arvalid = 1'b0;
        m00_axi_rready  = 1'b0;

        case (state_q)
            StIdle: begin
                cmd_ready = !m00_axi_areset;
                if (cmd_valid && !m00_axi_areset) begin
                    addr_d     = cmd_addr;
                    len_d      = cmd_len;
                    count_d    = 8'd0;
                    resp_max_d = 2'b00;
                    len_err_d  = 1'b0;
                    state_d    = cmd_write ? StWaddr : StRaddr;
                end
            end
            StWaddr: begin
                m00_axi_awvalid = 1'b1;
                if (m00_axi_awready) state_d = StWdata;
            end
            StWdata: begin
                m00_axi_wvalid = wr_valid;
                wr_ready       = m00_axi_wready;
                m00_axi_wlast  = (count_q == len_q);
                if (wr_valid && m00_axi_wready) begin
                    count_d = count_q + 8'd1;
                    if (count_q == len_q) state_d = StWresp;
                end
            end
            StWresp: begin
                m00_axi_bready = 1'b1;
                if (m00_axi_bvalid) begin
                    done_resp_d = m00_axi_bresp;
                    done_d      = 1'b1;
                    state_d     = StIdle;
                end
            end
            StRaddr: begin
                m00_axi_arvalid = 1'b1;
                if (m00_axi_arready) state_d = StRdata;
            end
            StRdata: begin
                rd_valid       = m00_axi_rvalid;
                m00_axi_rready = rd_ready;
                if (m00_axi_rvalid && rd_ready) begin
                    count_d    = count_q + 8'd1;
                    resp_max_d = resp_max_now;
                    if (count_q == len_q && !m00_axi_rlast) len_err_d = 1'b1;
                    if (m00_axi_rlast) begin
                        done_d      = 1'b1;
                        state_d     = StIdle;
                        // early or missing rlast means the burst length was violated
                        done_resp_d = (len_err_q || count_q != len_q) ? 2'b10 : resp_max_now;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and latched-command registers with synchronous reset
    always_ff @(posedge m00_axi_aclk) begin
        if (m00_axi_areset) begin
            state_q     <= StIdle;
            addr_q      <= '0;
            len_q       <= 8'd0;
            count_q     <= 8'd0;
            resp_max_q  <= 2'b00;
            len_err_q   <= 1'b0;
            done_q      <= 1'b0;
            done_resp_q <= 2'b00;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            len_q       <= len_d;
            count_q     <= count_d;
            resp_max_q  <= resp_max_d;
            len_err_q   <= len_err_d;
            done_q      <= done_d;
            done_resp_q <= done_resp_d;
        end
    end

endmodule

// File: tb/tb_axi4_burst_master.sv
// Directed bench for axi4_burst_master: transaction table plus hand sequences for
// back-to-back command acceptance and mid-burst reset.
module tb_axi4_burst_master;

    localparam int DW = 512;
    localparam int AW = 6;
    localparam int IW = 1;
    localparam logic [63:0] AllOnes = '1;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid, cmd_ready, cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [7:0]    cmd_len;
    logic [DW-1:0] wr_data;
    logic          wr_valid, wr_ready;
    logic [DW-1:0] rd_data;
    logic          rd_valid, rd_ready;
    logic          done;
    logic [1:0]    done_resp;
    logic [IW-1:0] awid, arid, bid, rid;
    logic [AW-1:0] awaddr, araddr;
    logic [7:0]    awlen, arlen;
    logic [2:0]    awsize, arsize;
    logic [1:0]    awburst, arburst, bresp, rresp;
    logic          awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic          arvalid, arready, rlast, rvalid, rready;
    logic [DW-1:0] wdata, rdata;
    logic [DW/8-1:0] wstrb;

    always #5 clk = ~clk;

    axi4_burst_master dut (
        .m00_axi_aclk    (clk),
        .m00_axi_areset  (rst),
        .cmd_valid       (cmd_valid),
        .cmd_ready       (cmd_ready),
        .cmd_write       (cmd_write),
        .cmd_addr        (cmd_addr),
        .cmd_len         (cmd_len),
        .wr_data         (wr_data),
        .wr_valid        (wr_valid),
        .wr_ready        (wr_ready),
        .rd_data         (rd_data),
        .rd_valid        (rd_valid),
        .rd_ready        (rd_ready),
        .done            (done),
        .done_resp       (done_resp),
        .m00_axi_awid    (awid),
        .m00_axi_awaddr  (awaddr),
        .m00_axi_awlen   (awlen),
        .m00_axi_awsize  (awsize),
        .m00_axi_awburst (awburst),
        .m00_axi_awvalid (awvalid),
        .m00_axi_awready (awready),
        .m00_axi_wdata   (wdata),
        .m00_axi_wstrb   (wstrb),
        .m00_axi_wlast   (wlast),
        .m00_axi_wvalid  (wvalid),
        .m00_axi_wready  (wready),
        .m00_axi_bid     (bid),
        .m00_axi_bresp   (bresp),
        .m00_axi_bvalid  (bvalid),
        .m00_axi_bready  (bready),
        .m00_axi_arid    (arid),
        .m00_axi_araddr  (araddr),
        .m00_axi_arlen   (arlen),
        .m00_axi_arsize  (arsize),
        .m00_axi_arburst (arburst),
        .m00_axi_arvalid (arvalid),
        .m00_axi_arready (arready),
        .m00_axi_rid     (rid),
        .m00_axi_rdata   (rdata),
        .m00_axi_rresp   (rresp),
        .m00_axi_rlast   (rlast),
        .m00_axi_rvalid  (rvalid),
        .m00_axi_rready  (rready)
    );

    typedef struct {
        bit         write;
        logic [5:0] addr;
        logic [7:0] len;
        int         ax_delay;    // cycles before awready/arready
        bit         wr_gap;      // wr_valid toggles
        logic [1:0] bresp;
        int         err_beat;    // read beat index carrying err_resp (-1 none)
        logic [1:0] err_resp;
        int         rlast_beat;  // read beat index carrying rlast
        logic [1:0] exp_resp;
    } txn_t;

    txn_t tbl [7];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out waiting for the DUT", name);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [511:0] pat(input int b, input logic [5:0] a);
        logic [7:0] bb;
        bb = 8'(b);
        return {16{8'hA5, 2'b00, a, bb, 8'h3C}};
    endfunction

    task automatic clear_inputs();
        cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_len = '0;
        wr_data = '0; wr_valid = 0; rd_ready = 0;
        awready = 0; wready = 0; bid = '0; bresp = 2'b00; bvalid = 0;
        arready = 0; rid = '0; rdata = '0; rresp = 2'b00; rlast = 0; rvalid = 0;
    endtask

    task automatic issue_cmd(input txn_t t);
        cmd_valid = 1; cmd_write = t.write; cmd_addr = t.addr; cmd_len = t.len;
        #1;
        chk("cmd_ready", cmd_ready, 1);
        tick();
        cmd_valid = 0;
    endtask

    // Address phase; data-channel inputs are driven active to show they are gated off
    task automatic addr_phase(input txn_t t);
        for (int c = 0; c < 64; c++) begin
            bit rdy;
            rdy = (c >= t.ax_delay);
            awready = t.write ? rdy : 1'b0;
            arready = t.write ? 1'b0 : rdy;
            wready = 1; wr_valid = 1; rvalid = 1; rd_ready = 1;
            #1;
            chk("done_addr", done, 0);
            if (t.write) begin
                chk("awvalid", awvalid, 1);
                chk("awaddr", awaddr, t.addr);
                chk("awlen", awlen, t.len);
                chk("awsize", awsize, 6);
                chk("awburst", awburst, 1);
                chk("awid", awid, 0);
                chk("wvalid_pre_aw", wvalid, 0);
                chk("wr_ready_pre_aw", wr_ready, 0);
                chk("arvalid_in_write", arvalid, 0);
            end else begin
                chk("arvalid", arvalid, 1);
                chk("araddr", araddr, t.addr);
                chk("arlen", arlen, t.len);
                chk("arsize", arsize, 6);
                chk("arburst", arburst, 1);
                chk("arid", arid, 0);
                chk("rd_valid_pre_ar", rd_valid, 0);
                chk("rready_pre_ar", rready, 0);
                chk("awvalid_in_read", awvalid, 0);
            end
            tick();
            if (rdy) begin
                clear_inputs();
                return;
            end
        end
        clear_inputs();
        timeout("addr_phase");
    endtask

    task automatic write_body(input txn_t t);
        int beat = 0;
        bit fin = 0;
        for (int c = 0; c < 64 && !fin; c++) begin
            wready = 1;
            wr_valid = t.wr_gap ? (c % 2 == 0) : 1'b1;
            wr_data = pat(beat, t.addr);
            #1;
            chk("wvalid", wvalid, wr_valid);
            chk("wr_ready", wr_ready, 1);
            chk("awvalid_in_w", awvalid, 0);
            if (wr_valid) begin
                chk("wdata", wdata, pat(beat, t.addr));
                chk("wstrb", wstrb, AllOnes);
                chk("wlast", wlast, (beat == int'(t.len)));
            end
            tick();
            if (wr_valid) begin
                if (beat == int'(t.len)) fin = 1;
                beat++;
            end
        end
        if (!fin) timeout("write_beats");
        wr_valid = 0; wready = 0;
        #1;
        chk("bready", bready, 1);
        chk("wvalid_after_last", wvalid, 0);
        chk("done_before_b", done, 0);
        tick();
        bvalid = 1; bresp = t.bresp;
        #1;
        chk("bready_hs", bready, 1);
        tick();
        bvalid = 0; bresp = 2'b00;
    endtask

    task automatic read_body(input txn_t t);
        int beat = 0;
        bit fin = 0;
        for (int c = 0; c < 128 && !fin; c++) begin
            rvalid = 1;
            rdata = pat(beat, t.addr);
            rresp = (beat == t.err_beat) ? t.err_resp : 2'b00;
            rlast = (beat == t.rlast_beat);
            rd_ready = (c % 2 == 0);
            #1;
            chk("rd_valid", rd_valid, 1);
            chk("rd_data", rd_data, pat(beat, t.addr));
            chk("rready", rready, rd_ready);
            chk("done_in_r", done, 0);
            tick();
            if (rd_ready) begin
                if (rlast) fin = 1;
                beat++;
            end
        end
        if (!fin) timeout("read_beats");
        clear_inputs();
    endtask

    task automatic check_done(input logic [1:0] exp);
        #1;
        chk("done_pulse", done, 1);
        chk("done_resp", done_resp, exp);
        tick();
        #1;
        chk("done_one_cycle", done, 0);
        chk("cmd_ready_after_done", cmd_ready, 1);
    endtask

    task automatic run_txn(input txn_t t);
        issue_cmd(t);
        addr_phase(t);
        if (t.write) write_body(t);
        else read_body(t);
        check_done(t.exp_resp);
    endtask

    initial begin
        txn_t ta, tb2;
        //           wr  addr   len   dly gap bresp  errb eresp  rlastb exp
        tbl[0] = '{1, 6'h10, 8'd3, 2, 0, 2'b00, -1, 2'b00, 0, 2'b00};
        tbl[1] = '{0, 6'h20, 8'd7, 1, 0, 2'b00, -1, 2'b00, 7, 2'b00};
        tbl[2] = '{0, 6'h08, 8'd3, 0, 0, 2'b00, 1, 2'b10, 3, 2'b10};
        tbl[3] = '{0, 6'h0C, 8'd3, 0, 0, 2'b00, -1, 2'b00, 1, 2'b10};
        tbl[4] = '{1, 6'h3F, 8'd1, 0, 1, 2'b11, -1, 2'b00, 0, 2'b11};
        tbl[5] = '{0, 6'h01, 8'd1, 3, 0, 2'b00, -1, 2'b00, 2, 2'b10};
        tbl[6] = '{0, 6'h02, 8'd2, 0, 0, 2'b00, 0, 2'b01, 2, 2'b01};

        clear_inputs();
        rst = 1;
        tick(); tick(); tick();
        chk("rst_cmd_ready", cmd_ready, 0);
        chk("rst_awvalid", awvalid, 0);
        chk("rst_arvalid", arvalid, 0);
        chk("rst_done", done, 0);
        rst = 0;
        #1;
        chk("post_rst_cmd_ready", cmd_ready, 1);
        chk("post_rst_done_resp", done_resp, 0);
        tick();

        for (int i = 0; i < 7; i++) run_txn(tbl[i]);

        // len=0 write, then a read command held valid during the done cycle
        ta  = '{1, 6'h3F, 8'd0, 0, 0, 2'b00, -1, 2'b00, 0, 2'b00};
        tb2 = '{0, 6'h05, 8'd0, 0, 0, 2'b00, -1, 2'b00, 0, 2'b00};
        issue_cmd(ta);
        addr_phase(ta);
        write_body(ta);
        cmd_valid = 1; cmd_write = 0; cmd_addr = tb2.addr; cmd_len = tb2.len;
        #1;
        chk("b2b_done", done, 1);
        chk("b2b_cmd_ready", cmd_ready, 1);
        chk("b2b_done_resp", done_resp, 0);
        tick();
        cmd_valid = 0;
        #1;
        chk("b2b_accepted", arvalid, 1);
        chk("b2b_done_cleared", done, 0);
        addr_phase(tb2);
        read_body(tb2);
        check_done(2'b00);

        // reset during the second write beat
        ta = '{1, 6'h10, 8'd3, 0, 0, 2'b00, -1, 2'b00, 0, 2'b00};
        issue_cmd(ta);
        addr_phase(ta);
        wr_valid = 1; wready = 1; wr_data = pat(0, ta.addr);
        tick();
        wr_data = pat(1, ta.addr); rvalid = 1; rd_ready = 1;
        #1;
        chk("pre_rst_wvalid", wvalid, 1);
        rst = 1;
        tick();
        chk("mid_rst_wvalid", wvalid, 0);
        chk("mid_rst_wlast", wlast, 0);
        chk("mid_rst_wr_ready", wr_ready, 0);
        chk("mid_rst_awvalid", awvalid, 0);
        chk("mid_rst_arvalid", arvalid, 0);
        chk("mid_rst_bready", bready, 0);
        chk("mid_rst_rready", rready, 0);
        chk("mid_rst_rd_valid", rd_valid, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_done_resp", done_resp, 0);
        rst = 0;
        clear_inputs();
        #1;
        chk("rel_cmd_ready", cmd_ready, 1);
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("no_done_after_rst", done, 0);
        end
        run_txn(tbl[0]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/axi4_burst_master.md
AXI4_BURST_MASTER -- requirements
Module: axi4_burst_master

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 512, AXI data width (multiple of 8, max 1024).
REQ-002 SHALL have parameter ADDR_WIDTH, default 6, AXI address width.
REQ-003 SHALL have parameter ID_WIDTH, default 1, AXI ID width.
REQ-004 SHALL have one clock and a synchronous active-high reset: m00_axi_aclk in 1, rising-edge clock; m00_axi_areset in 1, synchronous active-high reset.
REQ-005 SHALL have command ports: cmd_valid in 1; cmd_ready out 1; cmd_write in 1 (1=write, 0=read); cmd_addr in ADDR_WIDTH; cmd_len in 8 (beats-1).
REQ-006 SHALL have write-source ports: wr_data in DATA_WIDTH; wr_valid in 1; wr_ready out 1.
REQ-007 SHALL have read-sink ports: rd_data out DATA_WIDTH; rd_valid out 1; rd_ready in 1.
REQ-008 SHALL have status ports: done out 1 (one-cycle completion pulse); done_resp out 2 (transaction response).
REQ-009 SHALL have AW ports: m00_axi_awid out ID_WIDTH; awaddr out ADDR_WIDTH; awlen out 8; awsize out 3; awburst out 2; awvalid out 1; awready in 1.
REQ-010 SHALL have W ports: m00_axi_wdata out DATA_WIDTH; wstrb out DATA_WIDTH/8; wlast out 1; wvalid out 1; wready in 1.
REQ-011 SHALL have B ports: m00_axi_bid in ID_WIDTH; bresp in 2; bvalid in 1; bready out 1.
REQ-012 SHALL have AR ports: m00_axi_arid out ID_WIDTH; araddr out ADDR_WIDTH; arlen out 8; arsize out 3; arburst out 2; arvalid out 1; arready in 1.
REQ-013 SHALL have R ports: m00_axi_rid in ID_WIDTH; rdata in DATA_WIDTH; rresp in 2; rlast in 1; rvalid in 1; rready out 1.

Function
REQ-014 SHALL implement FSM states IDLE, WADDR, WDATA, WRESP, RADDR, RDATA.
REQ-015 SHALL drive cmd_ready=1 only in IDLE; on cmd_valid&&cmd_ready it SHALL latch write, addr and len, then go to WADDR (write) or RADDR (read).
REQ-016 SHALL drive awvalid=1 in WADDR only and hold it, with awaddr/awlen stable, until awready; on handshake it SHALL go to WDATA.
REQ-017 SHALL present no W beat before the AW handshake completes.
REQ-018 SHALL, in WDATA, drive wvalid=wr_valid, wr_ready=wready, wdata=wr_data, wstrb all ones, and count beats with an 8-bit counter cleared on command accept.
REQ-019 SHALL assert wlast exactly when beat count==latched len; on the wlast handshake it SHALL go to WRESP.
REQ-020 SHALL drive bready=1 in WRESP; on bvalid it SHALL capture bresp into done_resp, pulse done next cycle, and return to IDLE.
REQ-021 SHALL drive arvalid=1 in RADDR only and hold it until arready, then go to RDATA.
REQ-022 SHALL, in RDATA, drive rd_valid=rvalid, rd_data=rdata, rready=rd_ready, and track the maximum rresp over all beats.
REQ-023 SHALL leave RDATA on the handshake where rlast=1, pulse done next cycle with done_resp=max rresp, and return to IDLE.
REQ-024 SHALL force done_resp=2'b10 (SLVERR) if rlast arrives before beat count==len or is absent when count==len.
REQ-025 SHALL drive constant awid=arid=0, awsize=arsize=log2(DATA_WIDTH/8) (6 for 512), and awburst=arburst=2'b01 (INCR).
REQ-026 SHALL accept a new command in the same cycle done is high; cmd_len=0 SHALL give a single beat with wlast on that beat.
REQ-027 SHALL hold wr_ready=0 outside WDATA and rd_valid=0 outside RDATA.

Reset
REQ-028 SHALL, on m00_axi_areset=1 at a clock edge, enter IDLE and set awvalid, wvalid, wlast, bready, arvalid, rready, done, done_resp, beat counter and latched command to 0; cmd_ready becomes 1 on the first cycle after reset deasserts.
REQ-029 SHALL, on reset mid-transaction, abandon the burst without a done pulse.

Verification
REQ-030 SHALL pass: write, addr=0x10, len=3, awready after 2 cycles, wready always 1 -> 4 W beats, wlast on beat 4 only, bresp=00 -> done pulse, done_resp=00.
REQ-031 SHALL pass: read, addr=0x20, len=7, rd_ready toggling 1/0 -> 8 beats forwarded in order, rready mirrors rd_ready, done after rlast, done_resp=00.
REQ-032 SHALL pass: read len=3 with rresp=10 on beat 2 -> done_resp=10.
REQ-033 SHALL pass: read len=3 with rlast on beat 2 -> done_resp=10, return to IDLE.
REQ-034 SHALL pass: write len=0 -> single beat with wlast=1; a second command held valid during the done cycle is accepted that cycle.
REQ-035 SHALL pass: reset asserted during WDATA beat 2 -> all valids 0 next cycle, no done pulse, cmd_ready=1 after reset release.
